// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding and the per-bit gate evaluator for the pipelined logic unit.
package logic_unit_pkg;

   typedef enum logic [2:0] {
      OP_NOT   = 3'd0,
      OP_AND   = 3'd1,
      OP_OR    = 3'd2,
      OP_NAND  = 3'd3,
      OP_NOR   = 3'd4,
      OP_XOR   = 3'd5,
      OP_XNOR  = 3'd6,
      OP_PASSB = 3'd7
   } op_e;

   // All eight gate outputs for one bit pair, indexed by opcode value.
   function automatic logic [7:0] gate_results(input logic a, input logic b);
      gate_results = {b, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
   endfunction

endpackage

// File: rtl/logic_unit_flags.sv
// Combinational result flags: zero, all-ones, parity and (with LOGIC_UNIT_POPCNT_EN) popcount.
module logic_unit_flags #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]           y,
   output logic                       zero,
   output logic                       ones,
   output logic                       parity
`ifdef LOGIC_UNIT_POPCNT_EN
   ,
   output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

   assign zero   = ~|y;
   assign ones   = &y;
   assign parity = ^y;

`ifdef LOGIC_UNIT_POPCNT_EN
   localparam int PCW = $clog2(WIDTH + 1);

   always_comb begin
      popcnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         popcnt = popcnt + PCW'(y[i]);
      end
   end
`endif

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready flow control and accumulator chaining.
// Optional popcount output is enabled by defining LOGIC_UNIT_POPCNT_EN.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 in_op,
   input  logic [WIDTH-1:0]           in_a,
   input  logic [WIDTH-1:0]           in_b,
   input  logic                       in_acc,
   input  logic                       acc_clr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_y,
   output logic                       out_zero,
   output logic                       out_ones,
   output logic                       out_parity,
   output logic [WIDTH-1:0]           acc
`ifdef LOGIC_UNIT_POPCNT_EN
   ,
   output logic [$clog2(WIDTH+1)-1:0] out_popcnt
`endif
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   op_e              s1_op;
   logic             s1_adv;
   logic             accept;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] result;
   logic             f_zero;
   logic             f_ones;
   logic             f_parity;

   // An accumulate beat waits for S1 to drain so acc already holds every earlier result.
   assign s1_adv    = s1_valid & (~out_valid | out_ready);
   assign in_ready  = (~s1_valid | s1_adv) & ~(in_acc & s1_valid);
   assign accept    = in_valid & in_ready;
   assign operand_a = in_acc ? acc : in_a;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= OP_NOT;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_a     <= operand_a;
         s1_b     <= in_b;
         s1_op    <= op_e'(in_op);
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [7:0] bit_res;
      assign bit_res   = gate_results(s1_a[i], s1_b[i]);
      assign result[i] = bit_res[s1_op];
   end

`ifdef LOGIC_UNIT_POPCNT_EN
   logic [$clog2(WIDTH+1)-1:0] f_popcnt;

   logic_unit_flags #(.WIDTH(WIDTH)) u_flags (
      .y      (result),
      .zero   (f_zero),
      .ones   (f_ones),
      .parity (f_parity),
      .popcnt (f_popcnt)
   );
`else
   logic_unit_flags #(.WIDTH(WIDTH)) u_flags (
      .y      (result),
      .zero   (f_zero),
      .ones   (f_ones),
      .parity (f_parity)
   );
`endif

   // acc_clr has priority over the result written when S2 loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_y      <= '0;
         out_zero   <= 1'b0;
         out_ones   <= 1'b0;
         out_parity <= 1'b0;
         acc        <= '0;
`ifdef LOGIC_UNIT_POPCNT_EN
         out_popcnt <= '0;
`endif
      end else begin
         if (s1_adv) begin
            out_valid  <= 1'b1;
            out_y      <= result;
            out_zero   <= f_zero;
            out_ones   <= f_ones;
            out_parity <= f_parity;
`ifdef LOGIC_UNIT_POPCNT_EN
            out_popcnt <= f_popcnt;
`endif
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (acc_clr) begin
            acc <= '0;
         end else if (s1_adv) begin
            acc <= result;
         end
      end
   end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: vector table, directed flow-control sequences, random scoreboard.
module tb_logic_unit_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_acc;
   logic       acc_clr;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_y;
   logic       out_zero;
   logic       out_ones;
   logic       out_parity;
   logic [7:0] acc;
`ifdef LOGIC_UNIT_POPCNT_EN
   logic [3:0] out_popcnt;
`endif

   int check_count = 0;
   int pass_count  = 0;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_acc     (in_acc),
      .acc_clr    (acc_clr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .out_zero   (out_zero),
      .out_ones   (out_ones),
      .out_parity (out_parity),
      .acc        (acc)
`ifdef LOGIC_UNIT_POPCNT_EN
      ,
      .out_popcnt (out_popcnt)
`endif
   );

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] y;
      logic       zero;
      logic       ones;
      logic       par;
   } vec_t;

   vec_t vecs[11];

   function automatic logic [7:0] model_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return ~a;
         3'd1:    return a & b;
         3'd2:    return a | b;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return a ^ b;
         3'd6:    return ~(a ^ b);
         default: return b;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic use_acc, input logic rdy);
      in_valid  = v;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      in_acc    = use_acc;
      out_ready = rdy;
   endtask

   // Checks result and flags of the beat currently presented against a model value.
   task automatic checkBeat(input string name, input logic [7:0] y);
      checkOutput({name, "_y"}, out_y, y);
      checkOutput({name, "_zero"}, out_zero, (y == 8'h00));
      checkOutput({name, "_ones"}, out_ones, (y == 8'hFF));
      checkOutput({name, "_par"}, out_parity, 32'($countones(y) % 2));
`ifdef LOGIC_UNIT_POPCNT_EN
      checkOutput({name, "_popcnt"}, out_popcnt, 32'($countones(y)));
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
      end
   endtask

   logic [7:0] q_y[$];
   logic [7:0] last_result;
   logic [7:0] exp_y;
   logic [7:0] opa;

   initial begin
      vecs[0]  = '{3'd0, 8'hF0, 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{3'd1, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{3'd2, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{3'd3, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{3'd4, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{3'd5, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{3'd6, 8'hF0, 8'h3C, 8'h33, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{3'd7, 8'hF0, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{3'd1, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{3'd6, 8'h55, 8'h55, 8'hFF, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{3'd5, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1};

      rst     = 1'b1;
      acc_clr = 1'b0;
      applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #2;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_y", out_y, 0);
      checkOutput("rst_zero", out_zero, 0);
      checkOutput("rst_ones", out_ones, 0);
      checkOutput("rst_parity", out_parity, 0);
      checkOutput("rst_acc", acc, 0);
      checkOutput("rst_in_ready", in_ready, 1);

      // Back-to-back vectors; each result appears two cycles after it is presented.
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         if (i < 11) applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b1);
         else applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
         #2;
         if (i < 11) checkOutput("vec_in_ready", in_ready, 1);
         if (i >= 2) begin
            checkOutput("vec_out_valid", out_valid, 1);
            checkOutput("vec_y", out_y, vecs[i-2].y);
            checkOutput("vec_zero", out_zero, vecs[i-2].zero);
            checkOutput("vec_ones", out_ones, vecs[i-2].ones);
            checkOutput("vec_par", out_parity, vecs[i-2].par);
            checkOutput("vec_acc", acc, vecs[i-2].y);
         end
      end
      idle(2);

      // Backpressure: three beats while the consumer stalls for four cycles.
      @(negedge clk); applyStimulus(1'b1, 3'd7, 8'h00, 8'h11, 1'b0, 1'b0); #2;
      checkOutput("bp_c0_in_ready", in_ready, 1);
      @(negedge clk); applyStimulus(1'b1, 3'd7, 8'h00, 8'h22, 1'b0, 1'b0); #2;
      checkOutput("bp_c1_in_ready", in_ready, 1);
      checkOutput("bp_c1_out_valid", out_valid, 0);
      @(negedge clk); applyStimulus(1'b1, 3'd7, 8'h00, 8'h33, 1'b0, 1'b0); #2;
      checkOutput("bp_c2_in_ready", in_ready, 0);
      checkOutput("bp_c2_out_valid", out_valid, 1);
      checkOutput("bp_c2_y", out_y, 8'h11);
      @(negedge clk); applyStimulus(1'b1, 3'd7, 8'h00, 8'h33, 1'b0, 1'b0); #2;
      checkOutput("bp_c3_in_ready", in_ready, 0);
      checkOutput("bp_c3_y_held", out_y, 8'h11);
      checkOutput("bp_c3_out_valid", out_valid, 1);
      @(negedge clk); applyStimulus(1'b1, 3'd7, 8'h00, 8'h33, 1'b0, 1'b1); #2;
      checkOutput("bp_c4_in_ready", in_ready, 1);
      checkOutput("bp_c4_y", out_y, 8'h11);
      @(negedge clk); applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1); #2;
      checkOutput("bp_c5_out_valid", out_valid, 1);
      checkOutput("bp_c5_y", out_y, 8'h22);
      @(negedge clk); #2;
      checkOutput("bp_c6_out_valid", out_valid, 1);
      checkOutput("bp_c6_y", out_y, 8'h33);
      @(negedge clk); #2;
      checkOutput("bp_c7_out_valid", out_valid, 0);
      idle(1);

      // Accumulate interlock: pass B=0xAA, then acc XOR 0xFF.
      @(negedge clk); applyStimulus(1'b1, 3'd7, 8'h00, 8'hAA, 1'b0, 1'b1); #2;
      checkOutput("acc_c0_in_ready", in_ready, 1);
      @(negedge clk); applyStimulus(1'b1, 3'd5, 8'h00, 8'hFF, 1'b1, 1'b1); #2;
      checkOutput("acc_c1_in_ready", in_ready, 0);
      @(negedge clk); #2;
      checkOutput("acc_c2_in_ready", in_ready, 1);
      checkOutput("acc_c2_y", out_y, 8'hAA);
      checkOutput("acc_c2_acc", acc, 8'hAA);
      @(negedge clk); applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1); #2;
      @(negedge clk); #2;
      checkOutput("acc_c4_out_valid", out_valid, 1);
      checkOutput("acc_c4_y", out_y, 8'h55);
      checkOutput("acc_c4_acc", acc, 8'h55);
      idle(1);

      // acc_clr on the same edge that S2 loads 0x77.
      @(negedge clk); applyStimulus(1'b1, 3'd7, 8'h00, 8'h77, 1'b0, 1'b1);
      @(negedge clk); applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1); acc_clr = 1'b1;
      @(negedge clk); acc_clr = 1'b0; #2;
      checkOutput("clr_out_valid", out_valid, 1);
      checkOutput("clr_y", out_y, 8'h77);
      checkOutput("clr_acc", acc, 8'h00);
      idle(1);

      // Reset with both stages occupied discards everything.
      @(negedge clk); applyStimulus(1'b1, 3'd7, 8'h00, 8'h5A, 1'b0, 1'b0);
      @(negedge clk); applyStimulus(1'b1, 3'd7, 8'h00, 8'h6B, 1'b0, 1'b0);
      @(negedge clk); applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0); #2;
      checkOutput("rmid_pre_out_valid", out_valid, 1);
      checkOutput("rmid_pre_acc", acc, 8'h5A);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0; #2;
      checkOutput("rmid_out_valid", out_valid, 0);
      checkOutput("rmid_acc", acc, 0);
      checkOutput("rmid_y", out_y, 0);
      checkOutput("rmid_in_ready", in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1); #2;
         checkOutput("rmid_no_beat", out_valid, 0);
      end

      // Random traffic against a transaction-level scoreboard; acc starts at zero here.
      last_result = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         applyStimulus(($urandom % 4) != 0, 3'($urandom % 8), 8'($urandom), 8'($urandom),
                       ($urandom % 4) == 0, ($urandom % 4) != 0);
         #2;
         if (out_valid && out_ready) begin
            if (q_y.size() == 0) checkOutput("rand_extra_beat", out_valid, 0);
            else begin
               exp_y = q_y.pop_front();
               checkBeat("rand", exp_y);
               checkOutput("rand_acc", acc, exp_y);
            end
         end
         if (in_valid && in_ready) begin
            opa = in_acc ? last_result : in_a;
            last_result = model_fn(in_op, opa, in_b);
            q_y.push_back(last_result);
         end
      end
      for (int c = 0; c < 10 && q_y.size() > 0; c++) begin
         @(negedge clk);
         applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
         #2;
         if (out_valid) begin
            exp_y = q_y.pop_front();
            checkBeat("drain", exp_y);
         end
      end
      checkOutput("drain_empty", q_y.size(), 0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
